// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: state codes,
// supported opcodes and the datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the sequencer state to the datapath controls.
// The *_rdy enables are gated with MEM_READY by the top level.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  output logic       o_mem_req,
  output logic       o_iord,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_aluop,
  output logic [1:0] o_pcsrc,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_regwrite,
  output logic       o_irwrite_rdy,
  output logic       o_pcwrite_rdy,
  output logic       o_memwrite_rdy,
  output logic       o_pcwrite,
  output logic       o_branch
);

  always_comb begin
    o_mem_req      = 1'b0;
    o_iord         = 1'b0;
    o_alusrca      = 1'b0;
    o_alusrcb      = SRCB_REGB;
    o_aluop        = ALUOP_ADD;
    o_pcsrc        = PCSRC_ALU;
    o_regdst       = 1'b0;
    o_memtoreg     = 1'b0;
    o_regwrite     = 1'b0;
    o_irwrite_rdy  = 1'b0;
    o_pcwrite_rdy  = 1'b0;
    o_memwrite_rdy = 1'b0;
    o_pcwrite      = 1'b0;
    o_branch       = 1'b0;
    case (i_state)
      ST_FETCH: begin
        o_mem_req     = 1'b1;
        o_alusrcb     = SRCB_FOUR;
        o_irwrite_rdy = 1'b1;
        o_pcwrite_rdy = 1'b1;
      end
      ST_DECODE: o_alusrcb = SRCB_IMMSH;
      ST_MEMADR, ST_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      ST_MEMRD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      ST_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      ST_MEMWR: begin
        o_mem_req      = 1'b1;
        o_iord         = 1'b1;
        o_memwrite_rdy = 1'b1;
      end
      ST_EXEC: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      ST_BRANCH: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_SUB;
        o_pcsrc   = PCSRC_ALUOUT;
        o_branch  = 1'b1;
      end
      ST_ADDIWB: o_regwrite = 1'b1;
      ST_JUMP: begin
        o_pcsrc   = PCSRC_JUMP;
        o_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic and
// the MEM_READY / ZERO qualification of the write enables.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] OPCODE,
  input  logic           ZERO,
  input  logic           MEM_READY,
  output logic           MEM_REQ,
  output logic           IORD,
  output logic           ALUSRCA,
  output logic [1:0]     ALUSRCB,
  output logic [1:0]     ALUOP,
  output logic [1:0]     PCSRC,
  output logic           REGDST,
  output logic           MEMTOREG,
  output logic           IRWRITE,
  output logic           MEMWRITE,
  output logic           REGWRITE,
  output logic           PC_EN,
  output logic           ILLEGAL
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] w_op;
  logic       w_irwrite_rdy;
  logic       w_pcwrite_rdy;
  logic       w_memwrite_rdy;
  logic       w_pcwrite;
  logic       w_branch;

  assign w_op = 6'(OPCODE);

  mips_ctrl_decode u_decode (
    .i_state       (r_state),
    .o_mem_req     (MEM_REQ),
    .o_iord        (IORD),
    .o_alusrca     (ALUSRCA),
    .o_alusrcb     (ALUSRCB),
    .o_aluop       (ALUOP),
    .o_pcsrc       (PCSRC),
    .o_regdst      (REGDST),
    .o_memtoreg    (MEMTOREG),
    .o_regwrite    (REGWRITE),
    .o_irwrite_rdy (w_irwrite_rdy),
    .o_pcwrite_rdy (w_pcwrite_rdy),
    .o_memwrite_rdy(w_memwrite_rdy),
    .o_pcwrite     (w_pcwrite),
    .o_branch      (w_branch)
  );

  // Write enables only fire in the cycle memory completes the access.
  assign IRWRITE  = w_irwrite_rdy & MEM_READY;
  assign MEMWRITE = w_memwrite_rdy & MEM_READY;
  assign PC_EN    = w_pcwrite | (w_pcwrite_rdy & MEM_READY) | (w_branch & ZERO);
  assign ILLEGAL  = (r_state == ST_DECODE) & ~op_supported(w_op);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:   w_next = ST_FETCH;
      ST_FETCH:  if (MEM_READY) w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_EXEC;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_ADDI:      w_next = ST_ADDIEX;
          OP_J:         w_next = ST_JUMP;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: w_next = (w_op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (MEM_READY) w_next = ST_MEMWB;
      ST_MEMWR:  if (MEM_READY) w_next = ST_FETCH;
      ST_EXEC:   w_next = ST_ALUWB;
      ST_ADDIEX: w_next = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: w_next = ST_FETCH;
      default:   w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_next;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer: each cycle's full control
// word is compared against a hand-built per-state constant.
module tb_mips_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OPCODE = 6'b0;
  logic       ZERO = 1'b0;
  logic       MEM_READY = 1'b1;
  logic       MEM_REQ, IORD, ALUSRCA, REGDST, MEMTOREG;
  logic       IRWRITE, MEMWRITE, REGWRITE, PC_EN, ILLEGAL;
  logic [1:0] ALUSRCB, ALUOP, PCSRC;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl #(.OPW(6)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .MEM_REQ(MEM_REQ), .IORD(IORD), .ALUSRCA(ALUSRCA), .ALUSRCB(ALUSRCB),
    .ALUOP(ALUOP), .PCSRC(PCSRC), .REGDST(REGDST), .MEMTOREG(MEMTOREG),
    .IRWRITE(IRWRITE), .MEMWRITE(MEMWRITE), .REGWRITE(REGWRITE),
    .PC_EN(PC_EN), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // {MEM_REQ,IORD,ALUSRCA,ALUSRCB,ALUOP,PCSRC,REGDST,MEMTOREG,IRWRITE,MEMWRITE,REGWRITE,PC_EN,ILLEGAL}
  logic [15:0] w_obs;
  assign w_obs = {MEM_REQ, IORD, ALUSRCA, ALUSRCB, ALUOP, PCSRC, REGDST,
                  MEMTOREG, IRWRITE, MEMWRITE, REGWRITE, PC_EN, ILLEGAL};

  localparam logic [15:0] C_ZERO     = 16'b0_0_0_00_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_FETCH    = 16'b1_0_0_01_00_00_0_0_1_0_0_1_0;
  localparam logic [15:0] C_FETCH_ST = 16'b1_0_0_01_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_DECODE   = 16'b0_0_0_11_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_DEC_ILL  = 16'b0_0_0_11_00_00_0_0_0_0_0_0_1;
  localparam logic [15:0] C_MEMADR   = 16'b0_0_1_10_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_MEMRD    = 16'b1_1_0_00_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_MEMWB    = 16'b0_0_0_00_00_00_0_1_0_0_1_0_0;
  localparam logic [15:0] C_MEMWR    = 16'b1_1_0_00_00_00_0_0_0_1_0_0_0;
  localparam logic [15:0] C_MEMWR_ST = 16'b1_1_0_00_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_EXEC     = 16'b0_0_1_00_10_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_ALUWB    = 16'b0_0_0_00_00_00_1_0_0_0_1_0_0;
  localparam logic [15:0] C_BR_Z1    = 16'b0_0_1_00_01_01_0_0_0_0_0_1_0;
  localparam logic [15:0] C_BR_Z0    = 16'b0_0_1_00_01_01_0_0_0_0_0_0_0;
  localparam logic [15:0] C_ADDIEX   = 16'b0_0_1_10_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] C_ADDIWB   = 16'b0_0_0_00_00_00_0_0_0_0_1_0_0;
  localparam logic [15:0] C_JUMP     = 16'b0_0_0_00_00_10_0_0_0_0_0_1_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle: drive this cycle's inputs just after the edge, then check.
  task automatic cyc(input string tag, input logic rdy, input logic z,
                     input logic [5:0] op, input logic [15:0] exp);
    @(posedge CLK);
    #1;
    MEM_READY = rdy;
    ZERO      = z;
    OPCODE    = op;
    #2;
    chk_eq(tag, w_obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b0, RT, C_ZERO);
    RST = 1'b0;

    cyc("lw_fetch",  1'b1, 1'b0, LW, C_FETCH);
    cyc("lw_decode", 1'b1, 1'b0, LW, C_DECODE);
    cyc("lw_memadr", 1'b1, 1'b0, LW, C_MEMADR);
    cyc("lw_memrd",  1'b1, 1'b0, LW, C_MEMRD);
    cyc("lw_memwb",  1'b1, 1'b0, LW, C_MEMWB);

    cyc("sw_fetch",    1'b1, 1'b0, SW, C_FETCH);
    cyc("sw_decode",   1'b1, 1'b0, SW, C_DECODE);
    cyc("sw_memadr",   1'b1, 1'b0, SW, C_MEMADR);
    cyc("sw_memwr_s1", 1'b0, 1'b0, SW, C_MEMWR_ST);
    cyc("sw_memwr_s2", 1'b0, 1'b0, SW, C_MEMWR_ST);
    cyc("sw_memwr",    1'b1, 1'b0, SW, C_MEMWR);

    cyc("beq1_fetch",  1'b1, 1'b0, BEQ, C_FETCH);
    cyc("beq1_decode", 1'b1, 1'b0, BEQ, C_DECODE);
    cyc("beq1_branch", 1'b1, 1'b1, BEQ, C_BR_Z1);
    cyc("beq0_fetch",  1'b1, 1'b1, BEQ, C_FETCH);
    cyc("beq0_decode", 1'b1, 1'b1, BEQ, C_DECODE);
    cyc("beq0_branch", 1'b1, 1'b0, BEQ, C_BR_Z0);

    cyc("j_fetch_st", 1'b0, 1'b0, JMP, C_FETCH_ST);
    cyc("j_fetch",    1'b1, 1'b0, JMP, C_FETCH);
    cyc("j_decode",   1'b1, 1'b1, JMP, C_DECODE);
    cyc("j_jump",     1'b1, 1'b0, JMP, C_JUMP);

    // MEM_READY, ZERO and OPCODE are deliberately disturbed outside their use.
    cyc("r_fetch",  1'b1, 1'b0, RT,  C_FETCH);
    cyc("r_decode", 1'b0, 1'b0, RT,  C_DECODE);
    cyc("r_exec",   1'b0, 1'b1, JMP, C_EXEC);
    cyc("r_aluwb",  1'b0, 1'b1, BAD, C_ALUWB);

    cyc("addi_fetch",  1'b1, 1'b0, ADDI, C_FETCH);
    cyc("addi_decode", 1'b1, 1'b0, ADDI, C_DECODE);
    cyc("addi_ex",     1'b1, 1'b0, ADDI, C_ADDIEX);
    cyc("addi_wb",     1'b1, 1'b0, ADDI, C_ADDIWB);

    cyc("ill_fetch",  1'b1, 1'b0, BAD, C_FETCH);
    cyc("ill_decode", 1'b1, 1'b0, BAD, C_DEC_ILL);

    cyc("lwr_fetch",  1'b1, 1'b0, LW, C_FETCH);
    cyc("lwr_decode", 1'b1, 1'b0, LW, C_DECODE);
    cyc("lwr_memadr", 1'b1, 1'b0, LW, C_MEMADR);
    cyc("lwr_stall",  1'b0, 1'b0, LW, C_MEMRD);
    #1;
    RST = 1'b1;
    #1;
    chk_eq("rst_async", w_obs, C_ZERO);
    cyc("rst_hold", 1'b1, 1'b0, LW, C_ZERO);
    RST = 1'b0;
    cyc("post_rst_fetch", 1'b1, 1'b0, LW, C_FETCH);
    cyc("post_rst_decode", 1'b1, 1'b0, LW, C_DECODE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath. It owns the select lines of every datapath multiplexer (address, ALU operand A/B, PC source, register destination, write-back source) and the write enables of PC, IR, register file and memory. It steps each instruction through fetch/decode/execute/memory/write-back states. A simple ready handshake stalls it on memory accesses.

## Interface
Parameters:
- OPW, 6, opcode width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- OPCODE  in  OPW  IR[31:26], valid from DECODE onward.
- ZERO  in  1  ALU zero flag, same cycle.
- MEM_READY  in  1  memory completes current access this cycle.
- MEM_REQ  out  1  memory access requested.
- IORD  out  1  address mux: 0 = PC, 1 = ALUOut.
- ALUSRCA  out  1  0 = PC, 1 = reg A.
- ALUSRCB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- ALUOP  out  2  00 = add, 01 = sub, 10 = use funct.
- PCSRC  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- REGDST  out  1  0 = rt, 1 = rd.
- MEMTOREG  out  1  0 = ALUOut, 1 = MDR.
- IRWRITE, MEMWRITE, REGWRITE  out  1 each  write enables.
- PC_EN  out  1  PCWRITE | (BRANCH & ZERO).
- ILLEGAL  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs are Moore decodes of the state. The exceptions are PC_EN (uses ZERO) and the MEM_READY-qualified enables listed below. Every output not listed for a state is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: MEM_REQ=1, IORD=0, ALUSRCA=0, ALUSRCB=01, ALUOP=00, PCSRC=00. IRWRITE=PCWRITE=MEM_READY. Hold until MEM_READY, then go to DECODE.
- DECODE: ALUSRCA=0, ALUSRCB=11, ALUOP=00. Next state by opcode:
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000000 (R-type) goes to EXEC.
  - 000100 (beq) goes to BRANCH.
  - 001000 (addi) goes to ADDIEX.
  - 000010 (j) goes to JUMP.
  - Any other opcode: ILLEGAL=1 for this cycle, then FETCH.
- MEMADR: ALUSRCA=1, ALUSRCB=10, ALUOP=00. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: MEM_REQ=1, IORD=1. Hold until MEM_READY, then go to MEMWB.
- MEMWB: REGDST=0, MEMTOREG=1, REGWRITE=1. Next state is FETCH.
- MEMWR: MEM_REQ=1, IORD=1, MEMWRITE=MEM_READY. Hold until MEM_READY, then go to FETCH.
- EXEC: ALUSRCA=1, ALUSRCB=00, ALUOP=10. Next state is ALUWB.
- ALUWB: REGDST=1, MEMTOREG=0, REGWRITE=1. Next state is FETCH.
- BRANCH: ALUSRCA=1, ALUSRCB=00, ALUOP=01, PCSRC=01, internal BRANCH=1. Next state is FETCH.
- ADDIEX: ALUSRCA=1, ALUSRCB=10, ALUOP=00. Next state is ADDIWB.
- ADDIWB: REGDST=0, MEMTOREG=0, REGWRITE=1. Next state is FETCH.
- JUMP: PCSRC=10, PCWRITE=1. Next state is FETCH.

## Timing
- RST asserted forces INIT immediately (asynchronous); all outputs are 0 while RST is high.
- The first FETCH is the first rising edge after RST deasserts.
- Cycles per instruction with MEM_READY tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle MEM_READY is low in FETCH, MEMRD or MEMWR adds one cycle. All outputs hold steady during a stall; IRWRITE, PCWRITE and MEMWRITE stay 0 until the ready cycle.
- MEM_READY is ignored outside FETCH, MEMRD and MEMWR.
- PC_EN in BRANCH follows ZERO combinationally in the same cycle. No other state uses ZERO.
- OPCODE is sampled only in DECODE and MEMADR; changes in other states have no effect.
- RST mid-instruction (including mid-stall) abandons the instruction. No write enable pulses after reset.

## Structure
- Package mips_ctrl_pkg holds:
  - the 4-bit state encodings (INIT=0, then FETCH through JUMP = 1..12);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - encodings for ALUSRCB, ALUOP and PCSRC.
- Sub-module mips_ctrl_decode: purely combinational, mapping state to the Moore outputs. The top module contains only the state register, next-state logic, and the MEM_READY/ZERO qualifications.

## Test plan
- Reset: hold RST=1 for 3 cycles with MEM_READY=1, then release. All outputs are 0 during reset. Cycle 1 after release is FETCH with IRWRITE=1, PC_EN=1, ALUSRCB=01.
- lw (OPCODE=100011, MEM_READY=1): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. REGWRITE=1 and MEMTOREG=1 only in cycle 5.
- sw with MEM_READY low for 2 cycles in MEMWR: MEMWR lasts 3 cycles. MEMWRITE=1 only in the third. sw totals 6 cycles.
- beq (000100): with ZERO=1, PC_EN=1 and PCSRC=01 in cycle 3. Repeat with ZERO=0: PC_EN=0 in cycle 3.
- j (000010), R-type, and addi (001000): 3/4/4 cycles. REGDST is 1 for R-type and 0 for addi. PCSRC=10 in JUMP.
- Opcode 111111: ILLEGAL=1 for one cycle in DECODE, then FETCH. Separately, assert RST during a MEMRD stall: INIT next, with no REGWRITE pulse.
